uart_tx_cfg: RTL and testbench

Runtime-configurable UART transmitter. It extends the basic 8N1 transmitter with a programmable data length, a parity bit, one or two stop bits, a valid/ready input handshake and CTS flow control. It sits between the mux datapath (byte source) and the physical TX pin, one instance per channel. Frame format and baud divisor are captured when a word is accepted, so software can reprogram them between frames without corrupting a frame in flight.

---
 rtl/uart_tx_cfg.sv | 175 +++++++++++++++++
 tb/tb_uart_tx_cfg.sv | 212 +++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_cfg.sv
// rtl/uart_tx_cfg.sv - runtime-configurable UART transmitter with parity, 1/2 stop bits and CTS gating
// Frame format and divisor are latched at accept so software may reprogram between frames.
module uart_tx_cfg #(
   parameter int MAX_DATA_BITS = 9,
   parameter int COUNTER_BITS  = 16
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     tx_valid,
   output logic                     tx_ready,
   input  logic [MAX_DATA_BITS-1:0] data_in,
   input  logic [COUNTER_BITS-1:0]  baud_divisor,
   input  logic [3:0]               data_bits,
   input  logic [1:0]               parity_mode,
   input  logic                     two_stop,
   input  logic                     flow_en,
   input  logic                     cts_n,
   output logic                     tx,
   output logic                     rts,
   output logic                     busy,
   output logic                     tx_done_tick
);

   typedef enum logic [2:0] {
      IDLE,
      START,
      DATA,
      PARITY,
      STOP
   } state_t;

   localparam logic [3:0]              MAX_NBITS = 4'(MAX_DATA_BITS);
   localparam logic [3:0]              MIN_NBITS = 4'd5;
   localparam logic [COUNTER_BITS-1:0] CNT_ONE   = COUNTER_BITS'(1);

   state_t                   state;
   logic [COUNTER_BITS-1:0]  cnt;
   logic [COUNTER_BITS-1:0]  div_q;
   logic [MAX_DATA_BITS-1:0] shreg;
   logic [3:0]               nbits_q;
   logic [3:0]               bit_idx;
   logic                     par_en_q;
   logic                     par_bit_q;
   logic                     two_stop_q;
   logic                     stop_idx;

   logic [3:0]               nbits_clamp;
   logic [MAX_DATA_BITS-1:0] data_masked;
   logic                     par_en;
   logic                     par_calc;
   logic                     bit_tick;
   logic                     accept;

   // Clamp the requested length and drop bits beyond it so parity only sees live bits.
   always_comb begin
      nbits_clamp = data_bits;
      if (data_bits < MIN_NBITS)
         nbits_clamp = MIN_NBITS;
      else if (data_bits > MAX_NBITS)
         nbits_clamp = MAX_NBITS;
      data_masked = '0;
      for (int i = 0; i < MAX_DATA_BITS; i++) begin
         if (i < int'(nbits_clamp))
            data_masked[i] = data_in[i];
      end
   end

   assign par_en   = (parity_mode == 2'b01) || (parity_mode == 2'b10);
   assign par_calc = (^data_masked) ^ (parity_mode == 2'b10);
   assign bit_tick = (cnt == div_q);

   assign tx_ready     = (state == IDLE) && !reset && !(flow_en && cts_n);
   assign accept       = tx_valid && tx_ready;
   assign busy         = (state != IDLE) && !reset;
   assign tx_done_tick = !reset && (state == STOP) && bit_tick && (stop_idx == two_stop_q);

   always_ff @(posedge clk) begin
      if (reset) begin
         state      <= IDLE;
         tx         <= 1'b1;
         rts        <= 1'b0;
         cnt        <= '0;
         div_q      <= '0;
         shreg      <= '0;
         nbits_q    <= MIN_NBITS;
         bit_idx    <= '0;
         par_en_q   <= 1'b0;
         par_bit_q  <= 1'b0;
         two_stop_q <= 1'b0;
         stop_idx   <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               tx  <= 1'b1;
               rts <= 1'b0;
               if (accept) begin
                  state      <= START;
                  cnt        <= '0;
                  div_q      <= baud_divisor;
                  shreg      <= data_masked;
                  nbits_q    <= nbits_clamp;
                  par_en_q   <= par_en;
                  par_bit_q  <= par_calc;
                  two_stop_q <= two_stop;
                  bit_idx    <= '0;
                  stop_idx   <= 1'b0;
                  tx         <= 1'b0;
                  rts        <= 1'b1;
               end
            end
            START: begin
               if (bit_tick) begin
                  state   <= DATA;
                  cnt     <= '0;
                  bit_idx <= '0;
                  tx      <= shreg[0];
               end else begin
                  cnt <= cnt + CNT_ONE;
               end
            end
            DATA: begin
               if (bit_tick) begin
                  cnt <= '0;
                  if (bit_idx == nbits_q - 4'd1) begin
                     if (par_en_q) begin
                        state <= PARITY;
                        tx    <= par_bit_q;
                     end else begin
                        state    <= STOP;
                        stop_idx <= 1'b0;
                        tx       <= 1'b1;
                     end
                  end else begin
                     bit_idx <= bit_idx + 4'd1;
                     shreg   <= shreg >> 1;
                     tx      <= shreg[1];
                  end
               end else begin
                  cnt <= cnt + CNT_ONE;
               end
            end
            PARITY: begin
               if (bit_tick) begin
                  state    <= STOP;
                  cnt      <= '0;
                  stop_idx <= 1'b0;
                  tx       <= 1'b1;
               end else begin
                  cnt <= cnt + CNT_ONE;
               end
            end
            STOP: begin
               if (bit_tick) begin
                  cnt <= '0;
                  if (stop_idx == two_stop_q) begin
                     state <= IDLE;
                     tx    <= 1'b1;
                     rts   <= 1'b0;
                  end else begin
                     stop_idx <= 1'b1;
                  end
               end else begin
                  cnt <= cnt + CNT_ONE;
               end
            end
            default: begin
               state <= IDLE;
               tx    <= 1'b1;
               rts   <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_uart_tx_cfg.sv
// tb/tb_uart_tx_cfg.sv - directed self-checking bench for uart_tx_cfg
// Expected line levels are hand-built frame vectors, bit 0 = start bit.
module tb_uart_tx_cfg;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        tx_valid = 1'b0;
   logic        tx_ready;
   logic [8:0]  data_in = '0;
   logic [15:0] baud_divisor = '0;
   logic [3:0]  data_bits = 4'd8;
   logic [1:0]  parity_mode = 2'b00;
   logic        two_stop = 1'b0;
   logic        flow_en = 1'b0;
   logic        cts_n = 1'b0;
   logic        tx;
   logic        rts;
   logic        busy;
   logic        tx_done_tick;

   int errors = 0;
   int checks = 0;

   uart_tx_cfg #(.MAX_DATA_BITS(9), .COUNTER_BITS(16)) dut (
      .clk          (clk),
      .reset        (reset),
      .tx_valid     (tx_valid),
      .tx_ready     (tx_ready),
      .data_in      (data_in),
      .baud_divisor (baud_divisor),
      .data_bits    (data_bits),
      .parity_mode  (parity_mode),
      .two_stop     (two_stop),
      .flow_en      (flow_en),
      .cts_n        (cts_n),
      .tx           (tx),
      .rts          (rts),
      .busy         (busy),
      .tx_done_tick (tx_done_tick)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic obs, input logic exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %b expected %b at %0t", tag, obs, exp, $time);
      end
   endtask

   // Present a word, wait (bounded) for acceptance, then scramble inputs to prove capture.
   task automatic start_word(input logic [8:0] d, input logic [3:0] nb, input logic [1:0] pm,
                             input logic ts, input logic [15:0] dv, input logic hold);
      int n;
      data_in      = d;
      data_bits    = nb;
      parity_mode  = pm;
      two_stop     = ts;
      baud_divisor = dv;
      tx_valid     = 1'b1;
      #1;
      n = 0;
      while (!tx_ready && n < 100) begin
         @(negedge clk);
         n++;
      end
      check("accept_wait", n < 100, 1'b1);
      @(posedge clk);
      #1;
      if (!hold) tx_valid = 1'b0;
      data_in      = ~d;
      data_bits    = 4'd6;
      parity_mode  = ~pm;
      two_stop     = ~ts;
      baud_divisor = dv + 16'd3;
   endtask

   task automatic check_frame(input logic [15:0] vec, input int len, input int div,
                              input int cts_at, input int max_cyc);
      int total;
      int lim;
      total = len * (div + 1);
      lim = (max_cyc > 0) ? max_cyc : total;
      for (int k = 0; k < lim; k++) begin
         @(negedge clk);
         if (k == cts_at) cts_n = 1'b1;
         check($sformatf("tx[%0d]", k), tx, vec[k / (div + 1)]);
         check($sformatf("done[%0d]", k), tx_done_tick, k == total - 1);
         if (k == 0 || k == total - 1) begin
            check($sformatf("rts[%0d]", k), rts, 1'b1);
            check($sformatf("busy[%0d]", k), busy, 1'b1);
         end
         if (k == 0) check("ready_in_frame", tx_ready, 1'b0);
      end
   endtask

   task automatic check_idle(input string tag, input logic exp_ready);
      @(negedge clk);
      check({tag, "_tx"}, tx, 1'b1);
      check({tag, "_rts"}, rts, 1'b0);
      check({tag, "_busy"}, busy, 1'b0);
      check({tag, "_done"}, tx_done_tick, 1'b0);
      check({tag, "_ready"}, tx_ready, exp_ready);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      // Reset with a word pending: ready must stay low during reset.
      tx_valid = 1'b1;
      repeat (3) begin
         @(negedge clk);
         check("reset_ready", tx_ready, 1'b0);
         check("reset_busy", busy, 1'b0);
      end
      check("reset_tx", tx, 1'b1);
      check("reset_rts", rts, 1'b0);
      reset = 1'b0;
      tx_valid = 1'b0;
      check_idle("post_reset", 1'b1);

      // 8N1, divisor 3, 0xA5: 40 cycles.
      start_word(9'h0A5, 4'd8, 2'b00, 1'b0, 16'd3, 1'b0);
      check_frame(16'h034A, 10, 3, -1, 0);
      check_idle("a5_end", 1'b1);

      // 7E2, divisor 0, bit 7 set but ignored.
      start_word(9'h0B5, 4'd7, 2'b01, 1'b1, 16'd0, 1'b0);
      check_frame(16'h066A, 11, 0, -1, 0);
      check_idle("7e2_end", 1'b1);

      // 9O1, divisor 1, all ones: odd parity bit is 0; 24 cycles.
      start_word(9'h1FF, 4'd9, 2'b10, 1'b0, 16'd1, 1'b0);
      check_frame(16'h0BFE, 12, 1, -1, 0);
      check_idle("9o1_end", 1'b1);

      // data_bits = 2 clamps to 5; parity mode 11 means none.
      start_word(9'h1EA, 4'd2, 2'b11, 1'b0, 16'd0, 1'b0);
      check_frame(16'h0054, 7, 0, -1, 0);
      check_idle("clamp5_end", 1'b1);

      // data_bits = 15 clamps to 9.
      start_word(9'h155, 4'd15, 2'b00, 1'b0, 16'd0, 1'b0);
      check_frame(16'h06AA, 11, 0, -1, 0);
      check_idle("clamp9_end", 1'b1);

      // CTS gating: word held back for 50 cycles.
      flow_en  = 1'b1;
      cts_n    = 1'b1;
      tx_valid = 1'b1;
      for (int i = 0; i < 50; i++) begin
         @(negedge clk);
         check("cts_block_ready", tx_ready, 1'b0);
         check("cts_block_tx", tx, 1'b1);
         check("cts_block_busy", busy, 1'b0);
      end
      cts_n = 1'b0;
      start_word(9'h03C, 4'd8, 2'b00, 1'b0, 16'd0, 1'b0);
      check_frame(16'h0278, 10, 0, 3, 0);
      check_idle("cts_end", 1'b0);
      cts_n   = 1'b0;
      flow_en = 1'b0;
      check_idle("cts_release", 1'b1);

      // Back-to-back with tx_valid held; divisor changed during the first frame.
      start_word(9'h05A, 4'd8, 2'b00, 1'b0, 16'd2, 1'b1);
      data_in      = 9'h0C3;
      baud_divisor = 16'd7;
      check_frame(16'h02B4, 10, 2, -1, 0);
      data_bits    = 4'd8;
      parity_mode  = 2'b00;
      two_stop     = 1'b0;
      baud_divisor = 16'd2;
      check_idle("b2b_gap", 1'b1);
      @(posedge clk);
      #1;
      tx_valid     = 1'b0;
      baud_divisor = 16'd9;
      check_frame(16'h0386, 10, 2, -1, 0);
      check_idle("b2b_end", 1'b1);

      // Reset during DATA bit 4 aborts the frame with no done pulse.
      start_word(9'h0F0, 4'd8, 2'b00, 1'b0, 16'd1, 1'b0);
      check_frame(16'h03E0, 10, 1, -1, 11);
      reset = 1'b1;
      #1;
      check("midreset_ready", tx_ready, 1'b0);
      check("midreset_busy", busy, 1'b0);
      check("midreset_done", tx_done_tick, 1'b0);
      @(posedge clk);
      #1;
      reset = 1'b0;
      check_idle("after_abort", 1'b1);
      for (int i = 0; i < 30; i++) begin
         @(negedge clk);
         check("abort_tx", tx, 1'b1);
         check("abort_done", tx_done_tick, 1'b0);
      end
      start_word(9'h0A5, 4'd8, 2'b00, 1'b0, 16'd3, 1'b0);
      check_frame(16'h034A, 10, 3, -1, 0);
      check_idle("recover_end", 1'b1);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
